// File: rtl/sobel_pkg.sv
// Shared constants for the 5x5 Sobel window and edge stages.
// z-index to bit-offset mapping used by both stages to slice the packed matrix.
package sobel_pkg;
  localparam int WIN   = 5;
  localparam int PIX_W = 8;
  localparam int MAT_W = WIN * WIN * PIX_W;

  // LSB position of pixel z in the packed matrix (z0 sits at the top).
  function automatic int z_offset(input int z);
    return MAT_W - PIX_W * (z + 1);
  endfunction
endpackage

// File: rtl/sobel_window5_line_buffer.sv
// One line of pixel storage, DEPTH x WIDTH, synchronous read.
// Contents are never reset; the window valid flag masks stale data.
module line_buffer #(
  parameter int DEPTH = 640,
  parameter int WIDTH = 8,
  parameter int AW    = 10
) (
  input  logic             clock,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data
);
  logic [WIDTH-1:0] mem [DEPTH];

  // Read returns the old word when it collides with a write on the same edge.
  always_ff @(posedge clock) begin
    if (rd_en) rd_data <= mem[rd_addr];
    if (wr_en) mem[wr_addr] <= wr_data;
  end
endmodule

// File: rtl/sobel_window5.sv
// Raster pixel stream to 5x5 neighbourhood: four cascaded line buffers feed a 5x5 shift window.
// Optional SOBEL_ALIGN_EN adds edge_valid, win_valid delayed by three free-running registers.
module sobel_window5
  import sobel_pkg::*;
#(
  parameter int LINE_W = 640,
  parameter int PIX_W  = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [PIX_W-1:0]   pix_in,
  input  logic               pix_valid,
  input  logic               frame_start,
  output logic [MAT_W-1:0]   matrix_out,
  output logic               win_valid
`ifdef SOBEL_ALIGN_EN
  ,
  output logic               edge_valid
`endif
);
  localparam int CW = $clog2(LINE_W);
  localparam logic [CW-1:0] COL_LAST = CW'(LINE_W - 1);
  localparam logic [CW-1:0] COL_MIN  = CW'(WIN - 1);
  localparam logic [2:0]    ROW_SAT  = 3'(WIN - 1);

  logic [CW-1:0]    col, cur_col, s1_col;
  logic [2:0]       row, cur_row, s1_row;
  logic             s1_valid;
  logic [PIX_W-1:0] s1_pix;
  logic [PIX_W-1:0] lb_rd [4];
  logic [PIX_W-1:0] lb_wr [4];
  logic [PIX_W-1:0] new_col [WIN];
  logic [PIX_W-1:0] win [WIN][WIN];

  // frame_start overrides the running position for the pixel it marks.
  always_comb begin
    cur_col = frame_start ? '0 : col;
    cur_row = frame_start ? '0 : row;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      col      <= '0;
      row      <= '0;
      s1_valid <= 1'b0;
      s1_col   <= '0;
      s1_row   <= '0;
      s1_pix   <= '0;
    end else begin
      s1_valid <= pix_valid;
      if (pix_valid) begin
        s1_col <= cur_col;
        s1_row <= cur_row;
        s1_pix <= pix_in;
        if (cur_col == COL_LAST) begin
          col <= '0;
          row <= (cur_row == ROW_SAT) ? cur_row : cur_row + 3'd1;
        end else begin
          col <= cur_col + CW'(1);
          row <= cur_row;
        end
      end
    end
  end

  // Reads issue on the accept edge; the cascade write lands one edge later at the same column.
  always_comb begin
    lb_wr[0] = s1_pix;
    for (int k = 1; k < 4; k++) lb_wr[k] = lb_rd[k-1];
  end

  for (genvar k = 0; k < 4; k++) begin : g_lb
    line_buffer #(.DEPTH(LINE_W), .WIDTH(PIX_W), .AW(CW)) u_lb (
      .clock   (clock),
      .rd_en   (pix_valid),
      .rd_addr (cur_col),
      .rd_data (lb_rd[k]),
      .wr_en   (s1_valid),
      .wr_addr (s1_col),
      .wr_data (lb_wr[k])
    );
  end

  always_comb begin
    new_col[0] = lb_rd[3];
    new_col[1] = lb_rd[2];
    new_col[2] = lb_rd[1];
    new_col[3] = lb_rd[0];
    new_col[4] = s1_pix;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      win_valid <= 1'b0;
      for (int r = 0; r < WIN; r++)
        for (int c = 0; c < WIN; c++)
          win[r][c] <= '0;
    end else begin
      win_valid <= s1_valid && (s1_row == ROW_SAT) && (s1_col >= COL_MIN);
      if (s1_valid) begin
        for (int r = 0; r < WIN; r++) begin
          for (int c = 0; c < WIN - 1; c++) win[r][c] <= win[r][c+1];
          win[r][WIN-1] <= new_col[r];
        end
      end
    end
  end

  always_comb begin
    matrix_out = '0;
    for (int r = 0; r < WIN; r++)
      for (int c = 0; c < WIN; c++)
        matrix_out[z_offset(WIN * r + c) +: PIX_W] = win[r][c];
  end

`ifdef SOBEL_ALIGN_EN
  logic [2:0] ev_dly;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) ev_dly <= '0;
    else       ev_dly <= {ev_dly[1:0], win_valid};
  end

  assign edge_valid = ev_dly[2];
`endif
endmodule
